// File: rtl/ibex_ex_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ibex_ex_ctrl_if
// Purpose  : Bundle of every signal between ID, the EX datapath blocks,
//            writeback and the EX controller (ibex_ex_ctrl).
//            - slave  : the controller's view
//            - master : the environment's view (ID / ex blocks / WB)
// Ports    : in_valid_i/in_ready_o        ID handshake
//            mult_sel_i/div_sel_i         static decoder selects
//            mult_en_o/div_en_o           dynamic ex block enables
//            alu_instr_first_cycle_o      first execute cycle flag
//            ex_valid_i/ex_result_i       ex block result
//            imd_val_we_i/imd_val_d_i     intermediate value writes
//            imd_val_q_o                  intermediate value registers
//            multdiv_ready_id_o           downstream can take the result
//            wb_ready_i                   writeback accepts the result
//            out_valid_o/out_result_o     result to writeback
//            flush_i/timeout_o            kill request / abort pulse
// Revision : 1.0 - initial release
// ============================================================================
interface ibex_ex_ctrl_if;
    logic             in_valid_i;
    logic             in_ready_o;
    logic             mult_sel_i;
    logic             div_sel_i;
    logic             mult_en_o;
    logic             div_en_o;
    logic             alu_instr_first_cycle_o;
    logic             ex_valid_i;
    logic [31:0]      ex_result_i;
    logic [1:0]       imd_val_we_i;
    logic [1:0][33:0] imd_val_d_i;
    logic [1:0][33:0] imd_val_q_o;
    logic             multdiv_ready_id_o;
    logic             wb_ready_i;
    logic             out_valid_o;
    logic [31:0]      out_result_o;
    logic             flush_i;
    logic             timeout_o;

    modport slave (
        input  in_valid_i, mult_sel_i, div_sel_i, ex_valid_i, ex_result_i,
               imd_val_we_i, imd_val_d_i, wb_ready_i, flush_i,
        output in_ready_o, mult_en_o, div_en_o, alu_instr_first_cycle_o,
               imd_val_q_o, multdiv_ready_id_o, out_valid_o, out_result_o,
               timeout_o
    );

    modport master (
        output in_valid_i, mult_sel_i, div_sel_i, ex_valid_i, ex_result_i,
               imd_val_we_i, imd_val_d_i, wb_ready_i, flush_i,
        input  in_ready_o, mult_en_o, div_en_o, alu_instr_first_cycle_o,
               imd_val_q_o, multdiv_ready_id_o, out_valid_o, out_result_o,
               timeout_o
    );
endinterface
`default_nettype wire

// File: rtl/ibex_ex_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ibex_ex_ctrl
// Purpose  : Execute-stage sequencing controller. Tracks single- and
//            multi-cycle instructions (IDLE / MULTI / HOLD), gates the
//            multiplier/divider enables, owns the two intermediate value
//            registers, and holds a finished result while writeback stalls.
// Ports    : clk_i  - core clock, rising edge
//            rst_i  - synchronous active-high reset
//            bus    - ibex_ex_ctrl_if.slave (see interface file)
// Params   : TimeoutCycles (2..255, default 64) - MULTI abort limit
// Config   : IBEX_EX_CTRL_TIMEOUT_EN - when defined, a MULTI instruction
//            still without a result when the cycle counter reaches
//            TimeoutCycles is aborted with a one-cycle timeout_o pulse.
//            When undefined, timeout_o is 0 and MULTI waits indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module ibex_ex_ctrl #(
    parameter int unsigned TimeoutCycles = 64
) (
    input  wire          clk_i,
    input  wire          rst_i,
    ibex_ex_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MULTI = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam logic [7:0] c_TIMEOUT = 8'(TimeoutCycles);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [1:0][33:0] r_imd;
    logic [31:0]      r_result;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_cur;

    logic             w_in_ready;
    logic             w_out_valid;
    logic [31:0]      w_out_result;
    logic             w_mult_en;
    logic             w_div_en;
    logic             w_first;
    logic             w_mdr;
    logic             w_timeout;
    logic             w_imd_wr;
    logic             w_imd_clr;
    logic             w_capture;
    logic             w_to_arm;
    logic             w_to_hit;

    // Cycle number of the current instruction: the first cycle (IDLE) is
    // always 1; afterwards the register holds the running count.
    assign w_cnt_cur = (r_state == ST_IDLE) ? 8'd1 : r_cnt;

`ifdef IBEX_EX_CTRL_TIMEOUT_EN
    assign w_to_arm = 1'b1;
`else
    assign w_to_arm = 1'b0;
`endif

    // The limit compare is shared by both builds; the arm bit removes it
    // entirely when the abort feature is not built in.
    assign w_to_hit = w_to_arm & (w_cnt_cur == c_TIMEOUT);

    always_comb begin
        w_state_nxt  = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_out_result = bus.ex_result_i;
        w_mult_en    = 1'b0;
        w_div_en     = 1'b0;
        w_first      = 1'b0;
        w_mdr        = 1'b0;
        w_timeout    = 1'b0;
        w_imd_wr     = 1'b0;
        w_imd_clr    = 1'b0;
        w_capture    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_mdr = bus.wb_ready_i;
                if (bus.in_valid_i) begin
                    w_first     = 1'b1;
                    w_mult_en   = bus.mult_sel_i;
                    w_div_en    = bus.div_sel_i;
                    w_imd_wr    = 1'b1;
                    w_out_valid = bus.ex_valid_i;
                    if (bus.ex_valid_i) begin
                        if (bus.wb_ready_i) begin
                            w_in_ready = 1'b1;
                        end else begin
                            w_state_nxt = ST_HOLD;
                            w_capture   = 1'b1;
                        end
                    end else begin
                        w_state_nxt = ST_MULTI;
                    end
                end
            end
            ST_MULTI: begin
                w_mdr       = bus.wb_ready_i;
                w_mult_en   = bus.mult_sel_i;
                w_div_en    = bus.div_sel_i;
                w_imd_wr    = 1'b1;
                w_out_valid = bus.ex_valid_i;
                if (bus.ex_valid_i) begin
                    if (bus.wb_ready_i) begin
                        w_in_ready  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_HOLD;
                        w_capture   = 1'b1;
                    end
                end else if (w_to_hit) begin
                    // Abort: retire without a result and drop partial state.
                    w_timeout   = 1'b1;
                    w_in_ready  = 1'b1;
                    w_imd_clr   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                w_out_valid  = 1'b1;
                w_out_result = r_result;
                if (bus.wb_ready_i) begin
                    w_in_ready  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Flush (and reset, so a killed instruction never appears retired)
        // overrides every transition and silences the handshakes.
        if (bus.flush_i || rst_i) begin
            w_state_nxt = ST_IDLE;
            w_in_ready  = 1'b0;
            w_out_valid = 1'b0;
            w_mult_en   = 1'b0;
            w_div_en    = 1'b0;
            w_timeout   = 1'b0;
            w_imd_wr    = 1'b0;
            w_imd_clr   = 1'b1;
            w_capture   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_imd    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_capture) begin
                r_result <= bus.ex_result_i;
            end

            case (w_state_nxt)
                ST_MULTI: r_cnt <= (w_cnt_cur == 8'hFF) ? 8'hFF : w_cnt_cur + 8'd1;
                ST_HOLD:  r_cnt <= w_cnt_cur;
                default:  r_cnt <= 8'd0;
            endcase

            if (w_imd_clr) begin
                r_imd <= '0;
            end else if (w_imd_wr) begin
                for (int k = 0; k < 2; k++) begin
                    if (bus.imd_val_we_i[k]) begin
                        r_imd[k] <= bus.imd_val_d_i[k];
                    end
                end
            end
        end
    end

    assign bus.in_ready_o              = w_in_ready;
    assign bus.out_valid_o             = w_out_valid;
    assign bus.out_result_o            = w_out_result;
    assign bus.mult_en_o               = w_mult_en;
    assign bus.div_en_o                = w_div_en;
    assign bus.alu_instr_first_cycle_o = w_first;
    assign bus.multdiv_ready_id_o      = w_mdr;
    assign bus.timeout_o               = w_timeout;
    assign bus.imd_val_q_o             = r_imd;

endmodule
`default_nettype wire

// File: tb/tb_ibex_ex_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_ex_ctrl
// Purpose  : Self-checking bench for ibex_ex_ctrl. Instructions are described
//            by (latency, stall, result, flush point); the expected per-cycle
//            behaviour is derived from that description, results are queued
//            at issue and popped by an independent monitor on acceptance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_ex_ctrl;
    localparam int unsigned TO = 8;
`ifdef IBEX_EX_CTRL_TIMEOUT_EN
    localparam int DIV_L = 5;
`else
    localparam int DIV_L = 36;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] exp_q[$];
    logic [33:0] m_imd [2];

    ibex_ex_ctrl_if bus();

    ibex_ex_ctrl #(.TimeoutCycles(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_imd(input string name);
        chk({name, "_imd0"}, bus.imd_val_q_o[0], m_imd[0]);
        chk({name, "_imd1"}, bus.imd_val_q_o[1], m_imd[1]);
    endtask

    task automatic drive_zero();
        bus.in_valid_i   = 1'b0;
        bus.mult_sel_i   = 1'b0;
        bus.div_sel_i    = 1'b0;
        bus.ex_valid_i   = 1'b0;
        bus.ex_result_i  = '0;
        bus.imd_val_we_i = '0;
        bus.imd_val_d_i  = '0;
        bus.wb_ready_i   = 1'b0;
        bus.flush_i      = 1'b0;
    endtask

    // Scoreboard monitor: every accepted result must match the oldest issued one.
    always @(negedge clk) begin
        if (!rst && bus.out_valid_o && bus.wb_ready_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL result_unexpected: got %h expected none", bus.out_result_o);
            end else begin
                chk("result", {2'b00, bus.out_result_o}, {2'b00, exp_q.pop_front()});
            end
        end
    end

    // One instruction. L: cycles before the ex block result (0 = single cycle),
    // S: cycles writeback stalls after the result, F: flush cycle or -1.
    task automatic run_instr(input bit msel, input bit dsel, input int L, input int S,
                             input logic [31:0] R, input int F);
        int          last;
        bit          fl;
        logic [1:0]  we;
        logic [33:0] d0, d1;
        last = (F >= 0) ? F : L + S;
        if (F < 0) exp_q.push_back(R);
        for (int k = 0; k <= last; k++) begin
            fl = (k == F);
            we = 2'($urandom);
            d0 = {2'($urandom), 32'($urandom)};
            d1 = {2'($urandom), 32'($urandom)};
            bus.in_valid_i   = 1'b1;
            bus.mult_sel_i   = msel;
            bus.div_sel_i    = dsel;
            bus.ex_valid_i   = (k >= L);
            bus.ex_result_i  = (k == L) ? R : 32'($urandom);
            bus.wb_ready_i   = (k < L) ? 1'($urandom) : (k >= L + S);
            bus.flush_i      = fl;
            bus.imd_val_we_i = we;
            bus.imd_val_d_i  = {d1, d0};
            @(negedge clk);
            chk_imd("instr");
            if (fl) begin
                chk("flush_in_ready", bus.in_ready_o, 0);
                chk("flush_out_valid", bus.out_valid_o, 0);
                chk("flush_mult_en", bus.mult_en_o, 0);
                chk("flush_div_en", bus.div_en_o, 0);
            end else begin
                chk("first_cycle", bus.alu_instr_first_cycle_o, (k == 0));
                chk("mult_en", bus.mult_en_o, msel && (k <= L));
                chk("div_en", bus.div_en_o, dsel && (k <= L));
                chk("out_valid", bus.out_valid_o, (k >= L));
                chk("in_ready", bus.in_ready_o, (k == L + S));
                chk("multdiv_ready", bus.multdiv_ready_id_o, (k <= L) ? bus.wb_ready_i : 1'b0);
                chk("timeout", bus.timeout_o, 0);
            end
            tick();
            if (fl) begin
                m_imd[0] = '0;
                m_imd[1] = '0;
            end else if (k <= L) begin
                if (we[0]) m_imd[0] = d0;
                if (we[1]) m_imd[1] = d1;
            end
        end
        drive_zero();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int L, S, F, gap;
        drive_zero();
        m_imd[0] = '0;
        m_imd[1] = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state with inputs low
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready_o, 0);
        chk("rst_out_valid", bus.out_valid_o, 0);
        chk("rst_mult_en", bus.mult_en_o, 0);
        chk("rst_div_en", bus.div_en_o, 0);
        chk("rst_first", bus.alu_instr_first_cycle_o, 0);
        chk("rst_timeout", bus.timeout_o, 0);
        chk("rst_mdr", bus.multdiv_ready_id_o, 0);
        chk_imd("rst");
        tick();

        // Single-cycle ALU add, long divide, backpressure
        run_instr(1'b0, 1'b0, 0, 0, 32'h0000_0005, -1);
        run_instr(1'b0, 1'b1, DIV_L, 0, 32'h0000_00D1, -1);
        run_instr(1'b0, 1'b0, 0, 3, 32'hDEAD_BEEF, -1);
        run_instr(1'b1, 1'b0, 2, 2, 32'hCAFE_0001, -1);

        // Intermediate value write in MULTI, then flush
        bus.in_valid_i = 1'b1; bus.mult_sel_i = 1'b1;
        bus.imd_val_we_i = 2'b10; bus.imd_val_d_i = {34'h1_2345_6789, 34'h0};
        @(negedge clk); tick();
        bus.imd_val_we_i = 2'b01; bus.imd_val_d_i = {34'h2_FFFF_FFFF, 34'h3_0000_0001};
        @(negedge clk); tick();
        bus.imd_val_we_i = 2'b00; bus.flush_i = 1'b1;
        @(negedge clk);
        chk("imd_wr_q0", bus.imd_val_q_o[0], 34'h3_0000_0001);
        chk("imd_wr_q1", bus.imd_val_q_o[1], 34'h1_2345_6789);
        chk("imd_flush_in_ready", bus.in_ready_o, 0);
        chk("imd_flush_mult_en", bus.mult_en_o, 0);
        tick();
        bus.flush_i = 1'b0; bus.mult_sel_i = 1'b0;
        bus.ex_valid_i = 1'b1; bus.wb_ready_i = 1'b1; bus.ex_result_i = 32'h0000_1111;
        exp_q.push_back(32'h0000_1111);
        m_imd[0] = '0; m_imd[1] = '0;
        @(negedge clk);
        chk_imd("after_flush");
        chk("after_flush_first", bus.alu_instr_first_cycle_o, 1);
        chk("after_flush_in_ready", bus.in_ready_o, 1);
        tick();
        drive_zero();

        // Reset while holding a result: no retirement may be signalled
        bus.in_valid_i = 1'b1; bus.ex_valid_i = 1'b1; bus.ex_result_i = 32'h7777_0000;
        bus.imd_val_we_i = 2'b11; bus.imd_val_d_i = {34'h1_0000_0002, 34'h1_0000_0003};
        @(negedge clk); tick();
        bus.imd_val_we_i = 2'b00; bus.wb_ready_i = 1'b1; rst = 1'b1;
        @(negedge clk);
        chk("rst_hold_in_ready", bus.in_ready_o, 0);
        tick();
        rst = 1'b0; drive_zero();
        m_imd[0] = '0; m_imd[1] = '0;
        @(negedge clk);
        chk("rst_hold_out_valid", bus.out_valid_o, 0);
        chk_imd("rst_hold");
        tick();

        // Timeout behaviour
        bus.in_valid_i = 1'b1; bus.mult_sel_i = 1'b1; bus.wb_ready_i = 1'b1;
        bus.imd_val_we_i = 2'b11; bus.imd_val_d_i = {34'h0_AAAA_5555, 34'h3_5555_AAAA};
        @(negedge clk); tick();
        m_imd[0] = 34'h3_5555_AAAA; m_imd[1] = 34'h0_AAAA_5555;
        bus.imd_val_we_i = 2'b00;
`ifdef IBEX_EX_CTRL_TIMEOUT_EN
        for (int k = 1; k < int'(TO); k++) begin
            @(negedge clk);
            chk("to_timeout", bus.timeout_o, (k == int'(TO) - 1));
            chk("to_in_ready", bus.in_ready_o, (k == int'(TO) - 1));
            chk("to_out_valid", bus.out_valid_o, 0);
            tick();
        end
        m_imd[0] = '0; m_imd[1] = '0;
`else
        for (int k = 1; k < 300; k++) begin
            @(negedge clk);
            chk("noto_timeout", bus.timeout_o, 0);
            chk("noto_in_ready", bus.in_ready_o, 0);
            tick();
        end
        bus.ex_valid_i = 1'b1; bus.ex_result_i = 32'h0BAD_F00D;
        exp_q.push_back(32'h0BAD_F00D);
        @(negedge clk);
        chk("noto_retire", bus.in_ready_o, 1);
        chk("noto_first", bus.alu_instr_first_cycle_o, 0);
        tick();
`endif
        bus.mult_sel_i = 1'b0; bus.ex_valid_i = 1'b1; bus.ex_result_i = 32'h0000_2222;
        exp_q.push_back(32'h0000_2222);
        @(negedge clk);
        chk_imd("post_to");
        chk("post_to_first", bus.alu_instr_first_cycle_o, 1);
        chk("post_to_in_ready", bus.in_ready_o, 1);
        tick();
        drive_zero();

        // Randomized instruction stream
        for (int i = 0; i < 60; i++) begin
            L = $urandom_range(0, 5);
            S = $urandom_range(0, 3);
            F = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, L + S)) : -1;
            run_instr(1'($urandom), 1'($urandom), L, S, $urandom, F);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                bus.imd_val_we_i = 2'($urandom);
                bus.imd_val_d_i  = {34'($urandom), 34'($urandom)};
                bus.wb_ready_i   = 1'($urandom);
                @(negedge clk);
                chk("gap_first", bus.alu_instr_first_cycle_o, 0);
                chk("gap_in_ready", bus.in_ready_o, 0);
                chk_imd("gap");
                tick();
            end
            drive_zero();
        end

        @(negedge clk);
        chk("queue_empty", 34'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
